// File: rtl/lmg_move_sequencer.sv
// lmg_move_sequencer
// Drives the LMG legal-move generator. A board state and the castle and
// en-passant flags are latched on start, and LMG runs through reset,
// generate and drain. Each FIFO word holds eight packed move slots. Empty
// slots are dropped, and legal moves are sent one at a time on a
// valid/ready stream.
module lmg_move_sequencer #(
    parameter int MV_W        = 19,
    parameter int MV_PER_WORD = 8,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [255:0]      bstate_in_i,
    input  logic              lcas_in_i,
    input  logic              rcas_in_i,
    input  logic [7:0]        enp_in_i,
    output logic              lmg_reset_o,
    output logic [255:0]      lmg_bstate_o,
    output logic              lmg_lcas_o,
    output logic              lmg_rcas_o,
    output logic [7:0]        lmg_enp_o,
    input  logic              lmg_done_i,
    input  logic [159:0]      lmg_fifo_out_i,
    input  logic              lmg_fifo_empty_i,
    output logic              lmg_rden_o,
    output logic              mv_valid_o,
    input  logic              mv_ready_i,
    output logic [MV_W-1:0]   mv_data_o,
    output logic              busy_o,
    output logic              list_done_o,
    output logic [CNT_W-1:0]  move_count_o,
    output logic              timeout_err_o
);

    localparam int WORD_W = MV_W * MV_PER_WORD;
    localparam int SLOT_W = (MV_PER_WORD > 1) ? $clog2(MV_PER_WORD) : 1;
    localparam int TMR_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GEN,
        CHECK,
        FETCH,
        EMIT,
        FINISH
    } state_e;

    state_e              state_q;
    logic                lmgReset_q;
    logic [255:0]        lmgBstate_q;
    logic                lmgLcas_q;
    logic                lmgRcas_q;
    logic [7:0]          lmgEnp_q;
    logic [TMR_W-1:0]    genTimer_q;
    logic [WORD_W-1:0]   wordReg_q;
    logic [SLOT_W-1:0]   slotIdx_q;
    logic                mvValid_q;
    logic [MV_W-1:0]     mvData_q;
    logic                busy_q;
    logic                listDone_q;
    logic [CNT_W-1:0]    moveCount_q;
    logic                timeoutErr_q;

    logic [SLOT_W-1:0]   nextSlotIdx;
    logic [MV_W-1:0]     firstMove;
    logic [MV_W-1:0]     nextMove;
    logic                lastSlot;
    logic                handshake;

    // The top byte of the FIFO word carries no move slots.
    logic [159-WORD_W:0] unusedFifoBits;
    assign unusedFifoBits = lmg_fifo_out_i[159:WORD_W];

    // Slot selection: slot 1 is in the most significant position of the word.
    always_comb begin
        nextSlotIdx = slotIdx_q + SLOT_W'(1);
        firstMove   = lmg_fifo_out_i[WORD_W-1 -: MV_W];
        nextMove    = wordReg_q[MV_W*(MV_PER_WORD-1-int'(nextSlotIdx)) +: MV_W];
        lastSlot    = (slotIdx_q == SLOT_W'(MV_PER_WORD-1));
        handshake   = mvValid_q && mv_ready_i;
    end

    // Sequencer FSM: all stream, status and LMG control outputs are registered here.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            lmgReset_q   <= 1'b1;
            lmgBstate_q  <= '0;
            lmgLcas_q    <= 1'b0;
            lmgRcas_q    <= 1'b0;
            lmgEnp_q     <= '0;
            genTimer_q   <= '0;
            wordReg_q    <= '0;
            slotIdx_q    <= '0;
            mvValid_q    <= 1'b0;
            mvData_q     <= '0;
            busy_q       <= 1'b0;
            listDone_q   <= 1'b0;
            moveCount_q  <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            listDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        lmgBstate_q  <= bstate_in_i;
                        lmgLcas_q    <= lcas_in_i;
                        lmgRcas_q    <= rcas_in_i;
                        lmgEnp_q     <= enp_in_i;
                        moveCount_q  <= '0;
                        timeoutErr_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= LOAD;
                    end
                end
                LOAD: begin
                    lmgReset_q <= 1'b0;
                    genTimer_q <= '0;
                    state_q    <= GEN;
                end
                GEN: begin
                    if (lmg_done_i) begin
                        state_q <= CHECK;
                    end else if (genTimer_q == TMR_W'(TIMEOUT_CYC-1)) begin
                        timeoutErr_q <= 1'b1;
                        listDone_q   <= 1'b1;
                        lmgReset_q   <= 1'b1;
                        state_q      <= FINISH;
                    end else begin
                        genTimer_q <= genTimer_q + TMR_W'(1);
                    end
                end
                CHECK: begin
                    if (lmg_fifo_empty_i) begin
                        listDone_q <= 1'b1;
                        lmgReset_q <= 1'b1;
                        state_q    <= FINISH;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    wordReg_q <= lmg_fifo_out_i[WORD_W-1:0];
                    slotIdx_q <= '0;
                    mvValid_q <= ~firstMove[MV_W-1];
                    mvData_q  <= firstMove[MV_W-1] ? '0 : firstMove;
                    state_q   <= EMIT;
                end
                EMIT: begin
                    if (!mvValid_q || handshake) begin
                        if (handshake && (moveCount_q != '1)) begin
                            moveCount_q <= moveCount_q + CNT_W'(1);
                        end
                        if (lastSlot) begin
                            mvValid_q <= 1'b0;
                            mvData_q  <= '0;
                            state_q   <= CHECK;
                        end else begin
                            slotIdx_q <= nextSlotIdx;
                            mvValid_q <= ~nextMove[MV_W-1];
                            mvData_q  <= nextMove[MV_W-1] ? '0 : nextMove;
                        end
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The read strobe must line up with the empty flag in the same CHECK cycle.
    // For that reason it is decoded directly from the current state.
    assign lmg_rden_o    = (state_q == CHECK) && !lmg_fifo_empty_i;

    assign lmg_reset_o   = lmgReset_q;
    assign lmg_bstate_o  = lmgBstate_q;
    assign lmg_lcas_o    = lmgLcas_q;
    assign lmg_rcas_o    = lmgRcas_q;
    assign lmg_enp_o     = lmgEnp_q;
    assign mv_valid_o    = mvValid_q;
    assign mv_data_o     = mvData_q;
    assign busy_o        = busy_q;
    assign list_done_o   = listDone_q;
    assign move_count_o  = moveCount_q;
    assign timeout_err_o = timeoutErr_q;

endmodule

// File: tb/tb_lmg_move_sequencer.sv
// tb_lmg_move_sequencer
// Bench for lmg_move_sequencer. A behavioural LMG supplies lmg_done after a
// set delay and serves a queue of FIFO words. The expected move stream is the
// list of non-empty slots, in word and slot order.
module tb_lmg_move_sequencer;

    localparam int MV_W = 19;
    localparam int TMO  = 16;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [255:0] bstateIn;
    logic         lcasIn, rcasIn;
    logic [7:0]   enpIn;
    logic         lmgReset;
    logic [255:0] lmgBstate;
    logic         lmgLcas, lmgRcas;
    logic [7:0]   lmgEnp;
    logic         lmgDone;
    logic [159:0] lmgFifoOut;
    logic         lmgFifoEmpty;
    logic         lmgRden;
    logic         mvValid, mvReady;
    logic [18:0]  mvData;
    logic         busy, listDone;
    logic [7:0]   moveCount;
    logic         timeoutErr;

    int checks = 0;
    int errors = 0;

    logic [159:0] fifoQ[$];
    logic [18:0]  expQ[$];
    bit           doneEnable = 1'b0;
    int           doneDelay  = 5;
    int           genCycles  = 0;
    bit           rdenSeen   = 1'b0;

    typedef struct {
        int          nWords;
        logic [7:0]  mask;
        int          doneDelay;
        bit          doneEn;
        int          readyMode;
        logic [18:0] firstMove;
        bit          pokeStart;
        int          expMoves;
        int          expCount;
        bit          expTimeout;
        int          expRden;
    } vec_t;

    vec_t tbl[7];
    vec_t rv;

    always #5 clk = ~clk;

    lmg_move_sequencer #(.TIMEOUT_CYC(TMO)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .start_i          (start),
        .bstate_in_i      (bstateIn),
        .lcas_in_i        (lcasIn),
        .rcas_in_i        (rcasIn),
        .enp_in_i         (enpIn),
        .lmg_reset_o      (lmgReset),
        .lmg_bstate_o     (lmgBstate),
        .lmg_lcas_o       (lmgLcas),
        .lmg_rcas_o       (lmgRcas),
        .lmg_enp_o        (lmgEnp),
        .lmg_done_i       (lmgDone),
        .lmg_fifo_out_i   (lmgFifoOut),
        .lmg_fifo_empty_i (lmgFifoEmpty),
        .lmg_rden_o       (lmgRden),
        .mv_valid_o       (mvValid),
        .mv_ready_i       (mvReady),
        .mv_data_o        (mvData),
        .busy_o           (busy),
        .list_done_o      (listDone),
        .move_count_o     (moveCount),
        .timeout_err_o    (timeoutErr)
    );

    // LMG model, part 1: count the cycles spent out of reset and note the read strobe.
    always @(negedge clk) begin
        if (lmgReset !== 1'b0) genCycles = 0;
        else genCycles = genCycles + 1;
        rdenSeen = (lmgRden === 1'b1);
    end

    // LMG model, part 2: FIFO with a one-cycle read latency, plus the done flag.
    always @(posedge clk) begin
        #1;
        if (rdenSeen && fifoQ.size() > 0) lmgFifoOut = fifoQ.pop_front();
        lmgFifoEmpty = (fifoQ.size() == 0);
        lmgDone = doneEnable && (lmgReset === 1'b0) && (genCycles >= doneDelay);
    end

    task automatic checkOutput(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mkVec(int nw, logic [7:0] m, int dd, bit de, int rm, logic [18:0] fm,
                                   bit ps, int em, int ec, bit et, int er);
        vec_t v;
        v.nWords = nw; v.mask = m; v.doneDelay = dd; v.doneEn = de; v.readyMode = rm;
        v.firstMove = fm; v.pokeStart = ps; v.expMoves = em; v.expCount = ec;
        v.expTimeout = et; v.expRden = er;
        return v;
    endfunction

    task automatic checkResetValues(input string p);
        checkOutput({p, "_lmg_reset"}, lmgReset, 1);
        checkOutput({p, "_rden"}, lmgRden, 0);
        checkOutput({p, "_mv_valid"}, mvValid, 0);
        checkOutput({p, "_mv_data"}, mvData, 0);
        checkOutput({p, "_busy"}, busy, 0);
        checkOutput({p, "_list_done"}, listDone, 0);
        checkOutput({p, "_move_count"}, moveCount, 0);
        checkOutput({p, "_timeout_err"}, timeoutErr, 0);
        checkOutput({p, "_lmg_bstate"}, lmgBstate, 0);
        checkOutput({p, "_lmg_flags"}, {lmgLcas, lmgRcas, lmgEnp}, 0);
    endtask

    // Build the FIFO contents and the expected stream, then run one list to completion.
    task automatic applyStimulus(input vec_t v, input int id);
        logic [159:0] word;
        logic [18:0]  mv;
        logic [18:0]  prevData;
        int           gotMoves, rdenCnt;
        bit           stallPrev, finished;
        fifoQ.delete();
        expQ.delete();
        for (int w = 0; w < v.nWords; w++) begin
            word = {$urandom, $urandom, $urandom, $urandom, $urandom};
            for (int k = 1; k <= 8; k++) begin
                mv = 19'($urandom);
                if (w == 0 && k == 1 && v.firstMove != 0) mv = v.firstMove;
                if (v.mask[k-1]) begin
                    mv[18] = 1'b0;
                    expQ.push_back(mv);
                end else begin
                    mv[18] = 1'b1;
                end
                word[MV_W*(8-k) +: MV_W] = mv;
            end
            fifoQ.push_back(word);
        end
        doneEnable = v.doneEn;
        doneDelay  = v.doneDelay;
        @(negedge clk);
        bstateIn = {8{$urandom}};
        lcasIn   = 1'($urandom_range(0, 1));
        rcasIn   = 1'($urandom_range(0, 1));
        enpIn    = 8'($urandom);
        start    = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        gotMoves  = 0;
        rdenCnt   = 0;
        stallPrev = 1'b0;
        finished  = 1'b0;
        prevData  = '0;
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            case (v.readyMode)
                0:       mvReady = 1'b1;
                1:       mvReady = ~mvReady;
                default: mvReady = 1'($urandom_range(0, 1));
            endcase
            start = v.pokeStart && (cyc == 30);
            if (stallPrev) begin
                checkOutput($sformatf("v%0d_stall_valid", id), mvValid, 1);
                checkOutput($sformatf("v%0d_stall_data", id), mvData, prevData);
            end
            checkOutput($sformatf("v%0d_rden_while_valid", id), lmgRden & mvValid, 0);
            if (mvValid && mvReady) begin
                gotMoves++;
                checkOutput($sformatf("v%0d_move_expected", id), expQ.size() != 0, 1);
                if (expQ.size() != 0)
                    checkOutput($sformatf("v%0d_move_data", id), mvData, expQ.pop_front());
            end
            stallPrev = mvValid && !mvReady;
            prevData  = mvData;
            if (lmgRden) rdenCnt++;
            if (listDone) finished = 1'b1;
            else @(negedge clk);
        end
        start = 1'b0;
        checkOutput($sformatf("v%0d_list_done_seen", id), finished, 1);
        checkOutput($sformatf("v%0d_moves", id), gotMoves, v.expMoves);
        checkOutput($sformatf("v%0d_move_count", id), moveCount, v.expCount);
        checkOutput($sformatf("v%0d_timeout_err", id), timeoutErr, v.expTimeout);
        checkOutput($sformatf("v%0d_rden_pulses", id), rdenCnt, v.expRden);
        checkOutput($sformatf("v%0d_busy_at_done", id), busy, 1);
        @(negedge clk);
        mvReady = 1'b0;
        checkOutput($sformatf("v%0d_list_done_pulse", id), listDone, 0);
        checkOutput($sformatf("v%0d_idle_busy", id), busy, 0);
        checkOutput($sformatf("v%0d_count_stable", id), moveCount, v.expCount);
        checkOutput($sformatf("v%0d_idle_lmg_reset", id), lmgReset, 1);
    endtask

    // Input latching, LOAD/GEN reset sequencing and the done-with-empty-FIFO latency.
    task automatic checkLatchAndEmptyDone();
        logic [255:0] bs;
        int           tDone, rdenCnt;
        bit           seen;
        fifoQ.delete();
        doneEnable = 1'b1;
        doneDelay  = 4;
        @(negedge clk);
        bs = {8{$urandom}};
        bstateIn = bs; lcasIn = 1'b1; rcasIn = 1'b0; enpIn = 8'hA5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("load_lmg_reset", lmgReset, 1);
        checkOutput("load_busy", busy, 1);
        checkOutput("load_bstate", lmgBstate, bs);
        checkOutput("load_flags", {lmgLcas, lmgRcas, lmgEnp}, {1'b1, 1'b0, 8'hA5});
        bstateIn = ~bs; lcasIn = 1'b0; rcasIn = 1'b1; enpIn = 8'h5A;
        @(negedge clk);
        checkOutput("gen_lmg_reset", lmgReset, 0);
        checkOutput("gen_bstate_held", lmgBstate, bs);
        checkOutput("gen_flags_held", {lmgLcas, lmgRcas, lmgEnp}, {1'b1, 1'b0, 8'hA5});
        tDone = -1; seen = 1'b0; rdenCnt = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            if (lmgDone && tDone < 0) tDone = t;
            if (lmgRden) rdenCnt++;
            if (listDone) begin
                seen = 1'b1;
                checkOutput("empty_done_to_list_done", t - tDone, 2);
            end else begin
                @(negedge clk);
            end
        end
        checkOutput("empty_list_done_seen", seen, 1);
        checkOutput("empty_rden_never", rdenCnt, 0);
        checkOutput("empty_move_count", moveCount, 0);
        checkOutput("empty_timeout_err", timeoutErr, 0);
        @(negedge clk);
    endtask

    // Abort on timeout, then check that timeout_err stays set until the next start clears it.
    task automatic checkTimeout();
        bit seen;
        fifoQ.delete();
        doneEnable = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        checkOutput("tmo_gen_entry", lmgReset, 0);
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            if (listDone) begin
                seen = 1'b1;
                checkOutput("tmo_list_done_delay", t, TMO);
                checkOutput("tmo_err_with_done", timeoutErr, 1);
            end else begin
                @(negedge clk);
            end
        end
        checkOutput("tmo_list_done_seen", seen, 1);
        @(negedge clk);
        checkOutput("tmo_err_sticky_idle", timeoutErr, 1);
        doneEnable = 1'b1;
        doneDelay  = 2;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        checkOutput("tmo_err_cleared_by_start", timeoutErr, 0);
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            if (listDone) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput("tmo_followup_done", seen, 1);
        @(negedge clk);
    endtask

    // Reset with start held while a move is waiting on the stream.
    task automatic checkResetMidEmit();
        logic [159:0] word;
        bit           seen;
        int           ldCnt;
        fifoQ.delete();
        word = {$urandom, $urandom, $urandom, $urandom, $urandom};
        for (int k = 1; k <= 8; k++) word[MV_W*(8-k) + 18] = 1'b0;
        fifoQ.push_back(word);
        doneEnable = 1'b1;
        doneDelay  = 3;
        mvReady    = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            if (mvValid) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput("rst_emit_reached", seen, 1);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checkResetValues("rst_mid_emit");
        reset = 1'b0;
        start = 1'b0;
        fifoQ.delete();
        doneEnable = 1'b0;
        ldCnt = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (listDone) ldCnt++;
        end
        checkOutput("rst_no_list_done", ldCnt, 0);
        checkOutput("rst_stays_idle", busy, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; bstateIn = '0; lcasIn = 1'b0; rcasIn = 1'b0; enpIn = '0;
        mvReady = 1'b0; lmgDone = 1'b0; lmgFifoEmpty = 1'b1; lmgFifoOut = '0;

        tbl[0] = mkVec(1,  8'b0000_0101, 10, 1, 0, {1'b0, 6'd0, 6'd12, 6'd28}, 0, 2, 2, 0, 1);
        tbl[1] = mkVec(3,  8'hFF,        5,  1, 1, 19'd0, 0, 24,  24,  0, 3);
        tbl[2] = mkVec(0,  8'h00,        3,  1, 0, 19'd0, 0, 0,   0,   0, 0);
        tbl[3] = mkVec(2,  8'hFF,        3,  0, 0, 19'd0, 0, 0,   0,   1, 0);
        tbl[4] = mkVec(2,  8'h00,        2,  1, 0, 19'd0, 0, 0,   0,   0, 2);
        tbl[5] = mkVec(1,  8'h80,        7,  1, 2, 19'd0, 0, 1,   1,   0, 1);
        tbl[6] = mkVec(38, 8'hFF,        13, 1, 0, 19'd0, 1, 304, 255, 0, 38);

        repeat (3) @(negedge clk);
        checkResetValues("por");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) applyStimulus(tbl[i], i);

        checkLatchAndEmptyDone();
        checkTimeout();
        checkResetMidEmit();

        for (int r = 0; r < 8; r++) begin
            rv.nWords     = $urandom_range(0, 4);
            rv.mask       = 8'($urandom);
            rv.doneDelay  = $urandom_range(1, 12);
            rv.doneEn     = 1'b1;
            rv.readyMode  = 2;
            rv.firstMove  = '0;
            rv.pokeStart  = 1'b0;
            rv.expMoves   = rv.nWords * $countones(rv.mask);
            rv.expCount   = (rv.expMoves > 255) ? 255 : rv.expMoves;
            rv.expTimeout = 1'b0;
            rv.expRden    = rv.nWords;
            applyStimulus(rv, 100 + r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
